// File: rtl/bexkat1_pkg.sv
// Shared types for the register-file write-back path.
//   wb_entry_t    : one buffered retiring result
//   be_t          : write-enable encoding used for both general and SP writes
//   drain_state_t : write-back drain sequencer state
package bexkat1_pkg;

   localparam int unsigned              WB_WIDTH  = 32;
   localparam int unsigned              WB_COUNTP = 4;
   localparam logic [WB_COUNTP-1:0]     WB_SPREG  = 4'd15;

   typedef enum logic [1:0] {
      BE_NONE = 2'd0,
      BE_BYTE = 2'd1,
      BE_HALF = 2'd2,
      BE_WORD = 2'd3
   } be_t;

   typedef struct packed {
      logic [WB_COUNTP-1:0] addr;
      logic [WB_WIDTH-1:0]  data;
      be_t                  be;
      logic [WB_WIDTH-1:0]  sp_data;
      be_t                  sp_en;
   } wb_entry_t;

   typedef enum logic {
      DRAIN_IDLE  = 1'b0,
      DRAIN_SPLIT = 1'b1
   } drain_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr           : synchronous clear (empties the FIFO)
//   push, din     : enqueue (ignored when full)
//   pop           : dequeue head (ignored when empty)
//   head          : current head entry
//   full, empty   : occupancy flags
module wb_fifo
   import bexkat1_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      clr,
   input  logic      push,
   input  wb_entry_t din,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   wb_entry_t     mem_q [DEPTH];
   wb_entry_t     mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + (PW+1)'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side sequencer for the register file.
// Buffers retiring results, drains one register-file write per cycle, splits
// results that write both a general register and SP when the general
// destination is SP itself, and keeps a pending-write scoreboard for decode.
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   flush                     : drop buffered results, clear scoreboard
//   claim_valid/addr/sp/ready : decode destination claims
//   query1/2, hazard1/2       : decode RAW hazard lookup
//   res_valid/ready/addr/data/be/sp_data/sp_en : retiring results
//   write_addr/data/en, sp_data/sp_en          : register-file write ports
module regfile_writeback
   import bexkat1_pkg::*;
#(
   parameter int unsigned        WIDTH  = WB_WIDTH,
   parameter int unsigned        COUNTP = WB_COUNTP,
   parameter logic [COUNTP-1:0]  SPREG  = WB_SPREG,
   parameter int unsigned        DEPTH  = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush,
   input  logic              claim_valid,
   input  logic [COUNTP-1:0] claim_addr,
   input  logic              claim_sp,
   output logic              claim_ready,
   input  logic [COUNTP-1:0] query1,
   input  logic [COUNTP-1:0] query2,
   output logic              hazard1,
   output logic              hazard2,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [COUNTP-1:0] res_addr,
   input  logic [WIDTH-1:0]  res_data,
   input  logic [1:0]        res_be,
   input  logic [WIDTH-1:0]  res_sp_data,
   input  logic [1:0]        res_sp_en,
   output logic [COUNTP-1:0] write_addr,
   output logic [WIDTH-1:0]  write_data,
   output logic [1:0]        write_en,
   output logic [WIDTH-1:0]  sp_data,
   output logic [1:0]        sp_en
);

   localparam int unsigned NREG = 2**COUNTP;

   wb_entry_t    in_entry;
   wb_entry_t    head;
   logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
   drain_state_t state_q, state_d;
   logic [1:0]   cnt_q [NREG];
   logic [1:0]   cnt_d [NREG];
   logic [NREG-1:0] inc, dec;
   logic         claim_ok, claim_fire, conflict, blank;

   always_comb begin
      in_entry         = '0;
      in_entry.addr    = res_addr;
      in_entry.data    = res_data;
      in_entry.be      = be_t'(res_be);
      in_entry.sp_data = res_sp_data;
      in_entry.sp_en   = be_t'(res_sp_en);
   end

   // Reset and flush both suppress every side effect in the current cycle.
   assign blank     = !rst_ni || flush;
   assign fifo_push = !blank && res_valid && !fifo_full;
   assign res_ready = !rst_ni || !fifo_full;

   assign claim_ok    = (cnt_q[claim_addr] != 2'd3) &&
                        !(claim_sp && (cnt_q[SPREG] == 2'd3));
   assign claim_ready = !rst_ni || claim_ok;
   assign claim_fire  = !blank && claim_valid && claim_ok;

   assign hazard1 = rst_ni && (cnt_q[query1] != 2'd0);
   assign hazard2 = rst_ni && (cnt_q[query2] != 2'd0);

   assign conflict = (head.be != BE_NONE) && (head.sp_en != BE_NONE) &&
                     (head.addr == SPREG);

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (flush),
      .push   (fifo_push),
      .din    (in_entry),
      .pop    (fifo_pop),
      .head   (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Drain sequencer: a conflicting head is written in two cycles (general
   // register first, then SP) and only popped on the second.
   always_comb begin
      state_d    = state_q;
      fifo_pop   = 1'b0;
      write_addr = '0;
      write_data = '0;
      write_en   = '0;
      sp_data    = '0;
      sp_en      = '0;
      if (blank) begin
         state_d = DRAIN_IDLE;
      end else if (!fifo_empty) begin
         case (state_q)
            DRAIN_IDLE: begin
               if (head.be != BE_NONE) begin
                  write_addr = head.addr;
                  write_data = head.data;
                  write_en   = head.be;
               end
               if (conflict) begin
                  state_d = DRAIN_SPLIT;
               end else begin
                  if (head.sp_en != BE_NONE) begin
                     sp_data = head.sp_data;
                     sp_en   = head.sp_en;
                  end
                  fifo_pop = 1'b1;
               end
            end
            DRAIN_SPLIT: begin
               sp_data  = head.sp_data;
               sp_en    = head.sp_en;
               fifo_pop = 1'b1;
               state_d  = DRAIN_IDLE;
            end
            default: state_d = DRAIN_IDLE;
         endcase
      end
   end

   // Scoreboard: inc/dec are bit vectors so a claim or retire that names SP
   // twice (addr==SPREG plus SP flag) touches the counter only once.
   always_comb begin
      inc = '0;
      dec = '0;
      if (claim_fire) begin
         inc[claim_addr] = 1'b1;
         if (claim_sp) inc[SPREG] = 1'b1;
      end
      if (fifo_pop) begin
         if (head.be != BE_NONE)    dec[head.addr] = 1'b1;
         if (head.sp_en != BE_NONE) dec[SPREG]     = 1'b1;
      end
      for (int unsigned i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
         if (flush) begin
            cnt_d[i] = '0;
         end else if (inc[i] && !dec[i] && (cnt_q[i] != 2'd3)) begin
            cnt_d[i] = cnt_q[i] + 2'd1;
         end else if (dec[i] && !inc[i] && (cnt_q[i] != 2'd0)) begin
            cnt_d[i] = cnt_q[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= DRAIN_IDLE;
         cnt_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A retire for a register with no pending claim indicates a decode bug.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !flush) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (dec[i] && !inc[i]) begin
               assert (cnt_q[i] != 2'd0);
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush;
   logic        claim_valid;
   logic [3:0]  claim_addr;
   logic        claim_sp;
   logic        claim_ready;
   logic [3:0]  query1, query2;
   logic        hazard1, hazard2;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_addr;
   logic [31:0] res_data;
   logic [1:0]  res_be;
   logic [31:0] res_sp_data;
   logic [1:0]  res_sp_en;
   logic [3:0]  write_addr;
   logic [31:0] write_data;
   logic [1:0]  write_en;
   logic [31:0] sp_data;
   logic [1:0]  sp_en;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   regfile_writeback #(
      .WIDTH  (32),
      .COUNTP (4),
      .SPREG  (4'd15),
      .DEPTH  (2)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush       (flush),
      .claim_valid (claim_valid),
      .claim_addr  (claim_addr),
      .claim_sp    (claim_sp),
      .claim_ready (claim_ready),
      .query1      (query1),
      .query2      (query2),
      .hazard1     (hazard1),
      .hazard2     (hazard2),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_addr    (res_addr),
      .res_data    (res_data),
      .res_be      (res_be),
      .res_sp_data (res_sp_data),
      .res_sp_en   (res_sp_en),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .write_en    (write_en),
      .sp_data     (sp_data),
      .sp_en       (sp_en)
   );

   typedef struct {
      logic        cv;
      logic [3:0]  ca;
      logic        cs;
      logic [3:0]  ra;
      logic [31:0] rd;
      logic [1:0]  rbe;
      logic [31:0] rsd;
      logic [1:0]  rse;
      logic        h1;
      logic        h2;
      logic [3:0]  a_addr;
      logic [31:0] a_data;
      logic [1:0]  a_en;
      logic [31:0] a_spd;
      logic [1:0]  a_spen;
      logic [31:0] b_spd;
      logic [1:0]  b_spen;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] a, input logic [31:0] d,
                          input logic [1:0] en, input logic [31:0] spd, input logic [1:0] spen);
      chk({tag, ".write_addr"}, 64'(write_addr), 64'(a));
      chk({tag, ".write_data"}, 64'(write_data), 64'(d));
      chk({tag, ".write_en"},   64'(write_en),   64'(en));
      chk({tag, ".sp_data"},    64'(sp_data),    64'(spd));
      chk({tag, ".sp_en"},      64'(sp_en),      64'(spen));
   endtask

   task automatic next();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle_inputs();
      flush       = 1'b0;
      claim_valid = 1'b0;
      claim_addr  = '0;
      claim_sp    = 1'b0;
      res_valid   = 1'b0;
      res_addr    = '0;
      res_data    = '0;
      res_be      = '0;
      res_sp_data = '0;
      res_sp_en   = '0;
   endtask

   task automatic set_res(input logic [3:0] a, input logic [31:0] d, input logic [1:0] be,
                          input logic [31:0] spd, input logic [1:0] spe);
      res_valid   = 1'b1;
      res_addr    = a;
      res_data    = d;
      res_be      = be;
      res_sp_data = spd;
      res_sp_en   = spe;
   endtask

   initial begin
      // cv ca cs | ra rd rbe rsd rse | h1 h2 | A: addr data en spd spen | B: spd spen
      vecs[0] = '{1'b1, 4'd3,  1'b0, 4'd3,  32'hDEADBEEF, 2'd3, 32'h0,    2'd0, 1'b1, 1'b0,
                  4'd3,  32'hDEADBEEF, 2'd3, 32'h0,    2'd0, 32'h0, 2'd0};
      vecs[1] = '{1'b1, 4'd5,  1'b0, 4'd5,  32'h11,       2'd1, 32'h0,    2'd0, 1'b1, 1'b0,
                  4'd5,  32'h11,       2'd1, 32'h0,    2'd0, 32'h0, 2'd0};
      vecs[2] = '{1'b1, 4'd4,  1'b1, 4'd4,  32'hAAAA,     2'd3, 32'h1234, 2'd3, 1'b1, 1'b1,
                  4'd4,  32'hAAAA,     2'd3, 32'h1234, 2'd3, 32'h0, 2'd0};
      vecs[3] = '{1'b1, 4'd15, 1'b1, 4'd15, 32'h1,        2'd3, 32'h2,    2'd3, 1'b1, 1'b1,
                  4'd15, 32'h1,        2'd3, 32'h0,    2'd0, 32'h2, 2'd3};
      vecs[4] = '{1'b1, 4'd15, 1'b1, 4'd9,  32'hCAFE,     2'd0, 32'h55,   2'd2, 1'b1, 1'b1,
                  4'd0,  32'h0,        2'd0, 32'h55,   2'd2, 32'h0, 2'd0};
      vecs[5] = '{1'b0, 4'd2,  1'b0, 4'd2,  32'hFF,       2'd0, 32'h66,   2'd0, 1'b0, 1'b0,
                  4'd0,  32'h0,        2'd0, 32'h0,    2'd0, 32'h0, 2'd0};
      vecs[6] = '{1'b1, 4'd15, 1'b0, 4'd15, 32'h77,       2'd2, 32'h0,    2'd0, 1'b1, 1'b1,
                  4'd15, 32'h77,       2'd2, 32'h0,    2'd0, 32'h0, 2'd0};

      idle_inputs();
      query1 = '0;
      query2 = 4'd15;
      rst_ni = 1'b0;

      // Reset: outputs quiet, ready high, both during and after reset.
      #1;
      settle();
      chk_out("in_reset", 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);
      chk("in_reset.claim_ready", 64'(claim_ready), 64'd1);
      chk("in_reset.res_ready",   64'(res_ready),   64'd1);
      next();
      next();
      rst_ni = 1'b1;
      settle();
      chk_out("post_reset", 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);
      chk("post_reset.claim_ready", 64'(claim_ready), 64'd1);
      chk("post_reset.res_ready",   64'(res_ready),   64'd1);
      chk("post_reset.hazard1",     64'(hazard1),     64'd0);
      chk("post_reset.hazard2",     64'(hazard2),     64'd0);

      // Table-driven single-result drains.
      for (int i = 0; i < 7; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         next();
         claim_valid = vecs[i].cv;
         claim_addr  = vecs[i].ca;
         claim_sp    = vecs[i].cs;
         query1      = vecs[i].ca;
         query2      = 4'd15;
         next();
         claim_valid = 1'b0;
         claim_sp    = 1'b0;
         set_res(vecs[i].ra, vecs[i].rd, vecs[i].rbe, vecs[i].rsd, vecs[i].rse);
         settle();
         chk({t, ".h1_claimed"}, 64'(hazard1), 64'(vecs[i].h1));
         chk({t, ".h2_claimed"}, 64'(hazard2), 64'(vecs[i].h2));
         chk({t, ".res_ready"},  64'(res_ready), 64'd1);
         chk_out({t, ".pre"}, 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);
         next();
         res_valid = 1'b0;
         settle();
         chk_out({t, ".A"}, vecs[i].a_addr, vecs[i].a_data, vecs[i].a_en,
                 vecs[i].a_spd, vecs[i].a_spen);
         chk({t, ".h1_commit"}, 64'(hazard1), 64'(vecs[i].h1));
         chk({t, ".h2_commit"}, 64'(hazard2), 64'(vecs[i].h2));
         next();
         settle();
         chk_out({t, ".B"}, 4'd0, 32'h0, 2'd0, vecs[i].b_spd, vecs[i].b_spen);
         next();
         settle();
         chk_out({t, ".after"}, 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);
         chk({t, ".h1_clear"}, 64'(hazard1), 64'd0);
         chk({t, ".h2_clear"}, 64'(hazard2), 64'd0);
      end

      // Scoreboard saturation on r7.
      next();
      claim_valid = 1'b1;
      claim_addr  = 4'd7;
      claim_sp    = 1'b0;
      query1      = 4'd7;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("sat.claim_ready%0d", k), 64'(claim_ready), 64'd1);
         next();
      end
      settle();
      chk("sat.claim_full",  64'(claim_ready), 64'd0);
      chk("sat.hazard1",     64'(hazard1),     64'd1);
      next();
      set_res(4'd7, 32'h7, 2'd3, 32'h0, 2'd0);
      settle();
      chk("sat.claim_full2", 64'(claim_ready), 64'd0);
      next();
      res_valid = 1'b0;
      settle();
      chk("sat.retire_en",          64'(write_en),    64'd3);
      chk("sat.claim_full_retire",  64'(claim_ready), 64'd0);
      next();
      settle();
      chk("sat.claim_after_retire", 64'(claim_ready), 64'd1);
      next();
      claim_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_res(4'd7, 32'h70 + 32'(k), 2'd3, 32'h0, 2'd0);
         next();
         res_valid = 1'b0;
         next();
      end
      settle();
      chk("sat.hazard_drained", 64'(hazard1), 64'd0);

      // Fill the FIFO behind a split entry, then flush.
      next();
      claim_valid = 1'b1;
      claim_addr  = 4'd15;
      claim_sp    = 1'b1;
      next();
      claim_addr  = 4'd8;
      claim_sp    = 1'b0;
      next();
      claim_valid = 1'b0;
      set_res(4'd15, 32'h1, 2'd3, 32'h2, 2'd3);
      next();
      set_res(4'd8, 32'h8, 2'd3, 32'h0, 2'd0);
      settle();
      chk_out("fl.splitA", 4'd15, 32'h1, 2'd3, 32'h0, 2'd0);
      next();
      flush       = 1'b1;
      claim_valid = 1'b1;
      claim_addr  = 4'd10;
      set_res(4'd10, 32'hA, 2'd3, 32'h0, 2'd0);
      settle();
      chk("fl.full_res_ready", 64'(res_ready), 64'd0);
      chk("fl.write_en",       64'(write_en),  64'd0);
      chk("fl.sp_en",          64'(sp_en),     64'd0);
      next();
      idle_inputs();
      query1 = 4'd8;
      query2 = 4'd15;
      settle();
      chk("fl.res_ready", 64'(res_ready), 64'd1);
      chk("fl.hazard8",   64'(hazard1),   64'd0);
      chk("fl.hazard15",  64'(hazard2),   64'd0);
      chk_out("fl.after", 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);
      query1 = 4'd10;
      #1;
      chk("fl.hazard10_dropped", 64'(hazard1), 64'd0);
      next();
      settle();
      chk_out("fl.dropped_res", 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);

      // Reset in the middle of a split drain.
      next();
      claim_valid = 1'b1;
      claim_addr  = 4'd15;
      claim_sp    = 1'b1;
      next();
      claim_valid = 1'b0;
      claim_sp    = 1'b0;
      set_res(4'd15, 32'h3, 2'd3, 32'h4, 2'd3);
      next();
      res_valid = 1'b0;
      settle();
      chk_out("rst.splitA", 4'd15, 32'h3, 2'd3, 32'h0, 2'd0);
      rst_ni = 1'b0;
      #1;
      chk_out("rst.during", 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);
      chk("rst.claim_ready", 64'(claim_ready), 64'd1);
      chk("rst.res_ready",   64'(res_ready),   64'd1);
      next();
      rst_ni = 1'b1;
      settle();
      chk_out("rst.after", 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);
      chk("rst.hazard15", 64'(hazard2), 64'd0);
      next();
      settle();
      chk_out("rst.after2", 4'd0, 32'h0, 2'd0, 32'h0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
